// File: rtl/shift_loopback_seq_pkg.sv
// Shared definitions for the serial shift-register loopback sequencer.
// State encoding, default frame geometry and the frame counter width.
package shift_loopback_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DONE  = 3'd3,
      ST_ABORT = 3'd4
   } seq_state_e;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_DEPTH = 4;

   // The counter has to reach DEPTH+WIDTH-1 without wrapping.
   function automatic int cnt_bits(input int width, input int depth);
      return $clog2(width + depth + 1);
   endfunction

endpackage

// File: rtl/shift_loopback_seq.sv
// Loopback sequencer: serializes a host word MSB-first into the shift register,
// captures the delayed serial output and reports completion and match.
module shift_loopback_seq
   import shift_loopback_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             abort,
   output logic             sr_reset,
   output logic             sr_shift_in,
   input  logic             sr_shift_out,
   output logic             done,
   output logic             aborted,
   output logic [WIDTH-1:0] rx_data,
   output logic             match
);

   localparam int CW = cnt_bits(WIDTH, DEPTH);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEPTH + WIDTH - 1);
   localparam logic [CW-1:0] CNT_WIDTH = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

   seq_state_e       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] tx;
   logic [WIDTH-1:0] sent;
   logic [WIDTH-1:0] rx;
   logic [WIDTH-1:0] rx_shift;
   logic [WIDTH-1:0] rx_nxt;
   logic             cap_en;
   logic             drv_en;

   generate
      if (WIDTH == 1) begin : g_rx_w1
         assign rx_shift = sr_shift_out;
      end else begin : g_rx_wn
         assign rx_shift = {rx[WIDTH-2:0], sr_shift_out};
      end
   endgenerate

   // cnt never exceeds CNT_LAST while in RUN, so only the lower bound matters.
   always_comb begin
      drv_en = (state == ST_RUN) && (cnt < CNT_WIDTH);
      cap_en = (state == ST_RUN) && (cnt >= CNT_DEPTH);
      rx_nxt = cap_en ? rx_shift : rx;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         tx      <= '0;
         sent    <= '0;
         rx      <= '0;
         rx_data <= '0;
         match   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (load_valid) begin
                  tx    <= load_data;
                  sent  <= load_data;
                  state <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               cnt   <= '0;
               rx    <= '0;
               state <= abort ? ST_ABORT : ST_RUN;
            end
            ST_RUN: begin
               if (abort) begin
                  state <= ST_ABORT;
               end else begin
                  if (drv_en) tx <= tx << 1;
                  rx <= rx_nxt;
                  // Final capture lands in the same edge that publishes the result.
                  if (cnt == CNT_LAST) begin
                     state   <= ST_DONE;
                     rx_data <= rx_nxt;
                     match   <= (rx_nxt == sent);
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_DONE:  state <= abort ? ST_ABORT : ST_IDLE;
            ST_ABORT: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign load_ready  = (state == ST_IDLE);
   assign sr_reset    = (state == ST_CLEAR) || (state == ST_ABORT);
   assign sr_shift_in = drv_en ? tx[WIDTH-1] : 1'b0;
   assign done        = (state == ST_DONE);
   assign aborted     = (state == ST_ABORT);

endmodule
